// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI-lite 2:1 arbiter: FSM state encoding and
// default bus widths.
package axi_lite_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_A  = 3'd1,
    ST_RD_D  = 3'd2,
    ST_WR_AW = 3'd3,
    ST_WR_B  = 3'd4
  } arb_state_t;

endpackage

// File: rtl/axi_rr_pick2.sv
// Two-requester grant picker: a lone requester always wins; on a tie the
// winner is the master that was not granted last (RR_EN=1) or master 0.
module axi_rr_pick2 #(
  parameter bit RR_EN = 1'b1
) (
  input  logic [1:0] i_req,
  input  logic       i_rr_last,
  output logic       o_valid,
  output logic       o_grant
);

  // Grant decode from the request pair and the previous owner.
  always_comb begin
    o_valid = |i_req;
    case (i_req)
      2'b01:   o_grant = 1'b0;
      2'b10:   o_grant = 1'b1;
      2'b11:   o_grant = RR_EN ? ~i_rr_last : 1'b0;
      default: o_grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/axi_lite_arbiter_2to1.sv
// Serialises whole AXI-lite transactions from two masters onto one downstream
// port. Only control state is held; address and data pass straight through.
module axi_lite_arbiter_2to1
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter bit RR_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] s0_araddr,
  input  logic              s0_arvalid,
  output logic              s0_arready,
  output logic [DATA_W-1:0] s0_rdata,
  output logic              s0_rvalid,
  input  logic              s0_rready,
  input  logic [ADDR_W-1:0] s0_awaddr,
  input  logic              s0_awvalid,
  output logic              s0_awready,
  input  logic [DATA_W-1:0] s0_wdata,
  input  logic              s0_wvalid,
  output logic              s0_wready,
  output logic              s0_bvalid,
  input  logic              s0_bready,
  input  logic [ADDR_W-1:0] s1_araddr,
  input  logic              s1_arvalid,
  output logic              s1_arready,
  output logic [DATA_W-1:0] s1_rdata,
  output logic              s1_rvalid,
  input  logic              s1_rready,
  input  logic [ADDR_W-1:0] s1_awaddr,
  input  logic              s1_awvalid,
  output logic              s1_awready,
  input  logic [DATA_W-1:0] s1_wdata,
  input  logic              s1_wvalid,
  output logic              s1_wready,
  output logic              s1_bvalid,
  input  logic              s1_bready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic              m_bvalid,
  output logic              m_bready,
  output logic              busy,
  output logic              grant_id
);

  arb_state_t r_state;
  logic       r_grant;
  logic       r_rr_last;
  logic       r_aw_done;
  logic       r_w_done;

  logic w_pick_valid;
  logic w_pick;
  logic w_pick_aw;
  logic w_g_arvalid;
  logic w_g_rready;
  logic w_g_awvalid;
  logic w_g_wvalid;
  logic w_g_bready;
  logic w_ar_fire;
  logic w_r_fire;
  logic w_aw_fire;
  logic w_w_fire;
  logic w_b_fire;

  axi_rr_pick2 #(.RR_EN(RR_EN)) u_pick (
    .i_req     ({s1_arvalid | s1_awvalid, s0_arvalid | s0_awvalid}),
    .i_rr_last (r_rr_last),
    .o_valid   (w_pick_valid),
    .o_grant   (w_pick)
  );

  assign w_pick_aw   = w_pick  ? s1_awvalid : s0_awvalid;
  assign w_g_arvalid = r_grant ? s1_arvalid : s0_arvalid;
  assign w_g_rready  = r_grant ? s1_rready  : s0_rready;
  assign w_g_awvalid = r_grant ? s1_awvalid : s0_awvalid;
  assign w_g_wvalid  = r_grant ? s1_wvalid  : s0_wvalid;
  assign w_g_bready  = r_grant ? s1_bready  : s0_bready;

  assign m_araddr = r_grant ? s1_araddr : s0_araddr;
  assign m_awaddr = r_grant ? s1_awaddr : s0_awaddr;
  assign m_wdata  = r_grant ? s1_wdata  : s0_wdata;
  assign s0_rdata = m_rdata;
  assign s1_rdata = m_rdata;

  assign w_ar_fire = m_arvalid & m_arready;
  assign w_r_fire  = m_rvalid  & m_rready;
  assign w_aw_fire = m_awvalid & m_awready;
  assign w_w_fire  = m_wvalid  & m_wready;
  assign w_b_fire  = m_bvalid  & m_bready;

  assign busy     = (r_state != ST_IDLE);
  assign grant_id = r_grant;

  // Handshake routing: only the owner sees the downstream port, and only on
  // the channels its current phase uses.
  always_comb begin
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    m_awvalid  = 1'b0;
    m_wvalid   = 1'b0;
    m_bready   = 1'b0;
    s0_arready = 1'b0;
    s0_rvalid  = 1'b0;
    s0_awready = 1'b0;
    s0_wready  = 1'b0;
    s0_bvalid  = 1'b0;
    s1_arready = 1'b0;
    s1_rvalid  = 1'b0;
    s1_awready = 1'b0;
    s1_wready  = 1'b0;
    s1_bvalid  = 1'b0;
    case (r_state)
      ST_RD_A: begin
        m_arvalid  = w_g_arvalid;
        s0_arready = ~r_grant & m_arready;
        s1_arready =  r_grant & m_arready;
      end
      ST_RD_D: begin
        m_rready  = w_g_rready;
        s0_rvalid = ~r_grant & m_rvalid;
        s1_rvalid =  r_grant & m_rvalid;
      end
      ST_WR_AW: begin
        // A channel already handshaken is masked so it is issued exactly once.
        m_awvalid  = ~r_aw_done & w_g_awvalid;
        m_wvalid   = ~r_w_done  & w_g_wvalid;
        s0_awready = ~r_grant & ~r_aw_done & m_awready;
        s1_awready =  r_grant & ~r_aw_done & m_awready;
        s0_wready  = ~r_grant & ~r_w_done  & m_wready;
        s1_wready  =  r_grant & ~r_w_done  & m_wready;
      end
      ST_WR_B: begin
        m_bready  = w_g_bready;
        s0_bvalid = ~r_grant & m_bvalid;
        s1_bvalid =  r_grant & m_bvalid;
      end
      default: begin
      end
    endcase
  end

  // Transaction FSM: registered arbitration in IDLE, then one whole transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_grant   <= 1'b0;
      r_rr_last <= 1'b1;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_valid) begin
            r_grant   <= w_pick;
            r_rr_last <= w_pick;
            r_state   <= w_pick_aw ? ST_WR_AW : ST_RD_A;
          end
        end
        ST_RD_A: begin
          if (w_ar_fire) r_state <= ST_RD_D;
        end
        ST_RD_D: begin
          if (w_r_fire) r_state <= ST_IDLE;
        end
        ST_WR_AW: begin
          if ((r_aw_done | w_aw_fire) & (r_w_done | w_w_fire)) begin
            r_state   <= ST_WR_B;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end else begin
            if (w_aw_fire) r_aw_done <= 1'b1;
            if (w_w_fire)  r_w_done  <= 1'b1;
          end
        end
        ST_WR_B: begin
          if (w_b_fire) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_arbiter_2to1.sv
// Directed bench for axi_lite_arbiter_2to1: a vector table of single-master
// transactions plus hand-written sequences for arbitration and stall cases.
module tb_axi_lite_arbiter_2to1;

  logic        clk;
  logic        rst_n;
  logic [31:0] s0_araddr, s0_awaddr, s0_wdata, s1_araddr, s1_awaddr, s1_wdata;
  logic        s0_arvalid, s0_rready, s0_awvalid, s0_wvalid, s0_bready;
  logic        s1_arvalid, s1_rready, s1_awvalid, s1_wvalid, s1_bready;
  logic        s0_arready, s0_rvalid, s0_awready, s0_wready, s0_bvalid;
  logic        s1_arready, s1_rvalid, s1_awready, s1_wready, s1_bvalid;
  logic [31:0] s0_rdata, s1_rdata, m_araddr, m_awaddr, m_wdata, m_rdata;
  logic        m_arvalid, m_arready, m_rvalid, m_rready, m_awvalid, m_awready;
  logic        m_wvalid, m_wready, m_bvalid, m_bready, busy, grant_id;

  // Second instance, fixed priority, driven by the same masters and an always-ready slave.
  logic        q_s0_arready, q_s0_rvalid, q_s0_awready, q_s0_wready, q_s0_bvalid;
  logic        q_s1_arready, q_s1_rvalid, q_s1_awready, q_s1_wready, q_s1_bvalid;
  logic [31:0] q_s0_rdata, q_s1_rdata, q_m_araddr, q_m_awaddr, q_m_wdata;
  logic        q_m_arvalid, q_m_rready, q_m_awvalid, q_m_wvalid, q_m_bready, q_busy, q_grant_id;

  logic [14:0] hs_all;
  int          checks = 0;
  int          errors = 0;
  int          wcnt;

  typedef struct {
    bit          wr;
    bit          mst;
    logic [31:0] addr;
    logic [31:0] data;
    bit          exp_grant;
  } vec_t;
  vec_t vecs[5];

  axi_lite_arbiter_2to1 #(.ADDR_W(32), .DATA_W(32), .RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_araddr(s0_araddr), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
    .s0_rdata(s0_rdata), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s0_awaddr(s0_awaddr), .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
    .s0_wdata(s0_wdata), .s0_wvalid(s0_wvalid), .s0_wready(s0_wready),
    .s0_bvalid(s0_bvalid), .s0_bready(s0_bready),
    .s1_araddr(s1_araddr), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
    .s1_rdata(s1_rdata), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
    .s1_awaddr(s1_awaddr), .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
    .s1_wdata(s1_wdata), .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
    .s1_bvalid(s1_bvalid), .s1_bready(s1_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .busy(busy), .grant_id(grant_id)
  );

  axi_lite_arbiter_2to1 #(.ADDR_W(32), .DATA_W(32), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .s0_araddr(s0_araddr), .s0_arvalid(s0_arvalid), .s0_arready(q_s0_arready),
    .s0_rdata(q_s0_rdata), .s0_rvalid(q_s0_rvalid), .s0_rready(s0_rready),
    .s0_awaddr(s0_awaddr), .s0_awvalid(s0_awvalid), .s0_awready(q_s0_awready),
    .s0_wdata(s0_wdata), .s0_wvalid(s0_wvalid), .s0_wready(q_s0_wready),
    .s0_bvalid(q_s0_bvalid), .s0_bready(s0_bready),
    .s1_araddr(s1_araddr), .s1_arvalid(s1_arvalid), .s1_arready(q_s1_arready),
    .s1_rdata(q_s1_rdata), .s1_rvalid(q_s1_rvalid), .s1_rready(s1_rready),
    .s1_awaddr(s1_awaddr), .s1_awvalid(s1_awvalid), .s1_awready(q_s1_awready),
    .s1_wdata(s1_wdata), .s1_wvalid(s1_wvalid), .s1_wready(q_s1_wready),
    .s1_bvalid(q_s1_bvalid), .s1_bready(s1_bready),
    .m_araddr(q_m_araddr), .m_arvalid(q_m_arvalid), .m_arready(1'b1),
    .m_rdata(32'h0000_0000), .m_rvalid(1'b1), .m_rready(q_m_rready),
    .m_awaddr(q_m_awaddr), .m_awvalid(q_m_awvalid), .m_awready(1'b1),
    .m_wdata(q_m_wdata), .m_wvalid(q_m_wvalid), .m_wready(1'b1),
    .m_bvalid(1'b1), .m_bready(q_m_bready),
    .busy(q_busy), .grant_id(q_grant_id)
  );

  assign hs_all = {s0_arready, s0_rvalid, s0_awready, s0_wready, s0_bvalid,
                   s1_arready, s1_rvalid, s1_awready, s1_wready, s1_bvalid,
                   m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wcnt <= 0;
    else if (m_wvalid && m_wready) wcnt <= wcnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_all(input bit v);
    {s0_arvalid, s0_rready, s0_awvalid, s0_wvalid, s0_bready} = {5{v}};
    {s1_arvalid, s1_rready, s1_awvalid, s1_wvalid, s1_bready} = {5{v}};
    {m_arready, m_rvalid, m_awready, m_wready, m_bvalid} = {5{v}};
    {s0_araddr, s0_awaddr, s0_wdata, s1_araddr, s1_awaddr, s1_wdata} = {192{v}};
    m_rdata = {32{v}};
  endtask

  // Hold reset for two edges with every input high, check the quiet state, release.
  task automatic do_reset();
    rst_n = 1'b0;
    drive_all(1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("rst_quiet", {17'h0, hs_all}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_grant", {31'h0, grant_id}, 32'h0);
    drive_all(1'b0);
    rst_n = 1'b1;
  endtask

  task automatic set_master(input bit m, input bit wr, input logic [31:0] addr,
                            input logic [31:0] data, input bit on);
    if (m) begin
      s1_araddr = addr; s1_awaddr = addr; s1_wdata = data;
      s1_arvalid = on & ~wr; s1_awvalid = on & wr; s1_wvalid = on & wr;
      s1_rready = on; s1_bready = on;
    end else begin
      s0_araddr = addr; s0_awaddr = addr; s0_wdata = data;
      s0_arvalid = on & ~wr; s0_awvalid = on & wr; s0_wvalid = on & wr;
      s0_rready = on; s0_bready = on;
    end
  endtask

  // Downstream slave for one read owned by master m; returns at posedge+1 in IDLE.
  task automatic slave_read(input bit m, input logic [31:0] addr, input logic [31:0] rdata);
    int waited = 0;
    @(negedge clk);
    while (m_arvalid !== 1'b1 && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    check("rd_idle_cycles", waited, 32'd1);
    check("rd_grant", {31'h0, grant_id}, {31'h0, m});
    check("rd_araddr", m_araddr, addr);
    check("rd_busy", {31'h0, busy}, 32'd1);
    m_arready = 1'b1;
    #1;
    check("rd_arready", {30'h0, s1_arready, s0_arready}, m ? 32'd2 : 32'd1);
    check("rd_other_quiet", m ? {29'h0, s0_awready, s0_wready, s0_rvalid}
                              : {29'h0, s1_awready, s1_wready, s1_rvalid}, 32'h0);
    @(posedge clk);
    #1;
    m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = rdata;
    @(negedge clk);
    check("rd_rvalid", {30'h0, s1_rvalid, s0_rvalid}, m ? 32'd2 : 32'd1);
    check("rd_rdata", m ? s1_rdata : s0_rdata, rdata);
    check("rd_rready", {31'h0, m_rready}, 32'd1);
    @(posedge clk);
    #1;
    m_rvalid = 1'b0;
  endtask

  // Downstream slave for one write owned by master m, AW and W accepted together.
  task automatic slave_write(input bit m, input logic [31:0] addr, input logic [31:0] data);
    int waited = 0;
    @(negedge clk);
    while (m_awvalid !== 1'b1 && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    check("wr_idle_cycles", waited, 32'd1);
    check("wr_grant", {31'h0, grant_id}, {31'h0, m});
    check("wr_awaddr", m_awaddr, addr);
    check("wr_wdata", m_wdata, data);
    check("wr_wvalid", {31'h0, m_wvalid}, 32'd1);
    m_awready = 1'b1; m_wready = 1'b1;
    #1;
    check("wr_ready", {28'h0, s1_awready, s1_wready, s0_awready, s0_wready}, m ? 32'hC : 32'h3);
    @(posedge clk);
    #1;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b1;
    @(negedge clk);
    check("wr_bvalid", {30'h0, s1_bvalid, s0_bvalid}, m ? 32'd2 : 32'd1);
    check("wr_bready", {31'h0, m_bready}, 32'd1);
    @(posedge clk);
    #1;
    m_bvalid = 1'b0;
  endtask

  initial begin
    int waited;
    int starve;
    int nrd;
    vecs[0] = '{wr: 1'b0, mst: 1'b0, addr: 32'h1000_0000, data: 32'hDEAD_BEEF, exp_grant: 1'b0};
    vecs[1] = '{wr: 1'b1, mst: 1'b1, addr: 32'h0000_0020, data: 32'hA5A5_A5A5, exp_grant: 1'b1};
    vecs[2] = '{wr: 1'b0, mst: 1'b1, addr: 32'h0000_0044, data: 32'h1234_5678, exp_grant: 1'b1};
    vecs[3] = '{wr: 1'b1, mst: 1'b0, addr: 32'hFFFF_FFFC, data: 32'hFFFF_FFFF, exp_grant: 1'b0};
    vecs[4] = '{wr: 1'b0, mst: 1'b0, addr: 32'h0000_0000, data: 32'h0000_0000, exp_grant: 1'b0};

    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_master(vecs[i].mst, vecs[i].wr, vecs[i].addr, vecs[i].data, 1'b1);
      if (vecs[i].wr) slave_write(vecs[i].exp_grant, vecs[i].addr, vecs[i].data);
      else            slave_read(vecs[i].exp_grant, vecs[i].addr, vecs[i].data);
      set_master(vecs[i].mst, 1'b0, 32'h0, 32'h0, 1'b0);
    end

    // Tie from reset under round-robin: s0 read first, then s1 write.
    do_reset();
    set_master(1'b0, 1'b0, 32'h0000_0010, 32'h0, 1'b1);
    set_master(1'b1, 1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 1'b1);
    m_awready = 1'b1; m_wready = 1'b1;
    slave_read(1'b0, 32'h0000_0010, 32'h1111_2222);
    m_awready = 1'b0; m_wready = 1'b0;
    set_master(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    slave_write(1'b1, 32'h0000_0020, 32'hA5A5_A5A5);
    set_master(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);

    // Fixed priority: s1 starves while s0 keeps requesting.
    do_reset();
    set_master(1'b0, 1'b0, 32'h0000_0010, 32'h0, 1'b1);
    set_master(1'b1, 1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 1'b1);
    starve = 0; nrd = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (q_grant_id || q_s1_awready || q_s1_wready || q_m_awvalid) starve++;
      if (q_m_arvalid) nrd++;
    end
    check("prio_s1_starved", starve, 32'd0);
    check("prio_rd_count", nrd, 32'd10);
    @(posedge clk);
    #1;
    set_master(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    waited = 0;
    @(negedge clk);
    while (q_m_awvalid !== 1'b1 && waited < 10) begin
      waited++;
      @(negedge clk);
    end
    check("prio_s1_grant", {31'h0, q_grant_id}, 32'd1);
    check("prio_s1_awaddr", q_m_awaddr, 32'h0000_0020);

    // W accepted three cycles before AW; W must not be reissued.
    do_reset();
    set_master(1'b0, 1'b1, 32'h0000_0030, 32'h55AA_55AA, 1'b1);
    m_bvalid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (m_awvalid !== 1'b1 && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    check("wfirst_wvalid", {31'h0, m_wvalid}, 32'd1);
    m_wready = 1'b1;
    #1;
    check("wfirst_wready", {31'h0, s0_wready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("wfirst_wvalid_masked", {30'h0, m_wvalid, s0_wready}, 32'h0);
      check("wfirst_still_aw", {30'h0, m_awvalid, s0_bvalid}, 32'd2);
    end
    m_awready = 1'b1;
    #1;
    check("wfirst_awready", {31'h0, s0_awready}, 32'd1);
    @(posedge clk);
    #1;
    m_awready = 1'b0;
    @(negedge clk);
    check("wfirst_wr_b", {30'h0, s0_bvalid, m_bready}, 32'd3);
    @(posedge clk);
    #1;
    set_master(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    m_bvalid = 1'b0; m_wready = 1'b0;
    @(negedge clk);
    check("wfirst_w_count", wcnt, 32'd1);
    check("wfirst_idle", {31'h0, busy}, 32'd0);

    // Slave stalls AR and R while s1 waits.
    do_reset();
    set_master(1'b0, 1'b0, 32'h0000_0040, 32'h0, 1'b1);
    waited = 0;
    @(negedge clk);
    while (m_arvalid !== 1'b1 && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    set_master(1'b1, 1'b0, 32'h0000_0050, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_ar_readies", {30'h0, s1_arready, s0_arready}, 32'h0);
      check("stall_ar_owner", {31'h0, grant_id}, 32'd0);
      check("stall_araddr", m_araddr, 32'h0000_0040);
    end
    m_arready = 1'b1;
    #1;
    check("stall_ar_accept", {30'h0, s1_arready, s0_arready}, 32'd1);
    @(posedge clk);
    #1;
    m_arready = 1'b0; s0_arvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_r_wait", {29'h0, s1_arready, s0_rvalid, busy}, 32'd1);
    end
    m_rvalid = 1'b1; m_rdata = 32'hCAFE_F00D;
    #1;
    check("stall_r_valid", {30'h0, s1_rvalid, s0_rvalid}, 32'd1);
    check("stall_r_data", s0_rdata, 32'hCAFE_F00D);
    @(posedge clk);
    #1;
    m_rvalid = 1'b0; s0_rready = 1'b0;
    slave_read(1'b1, 32'h0000_0050, 32'h0BAD_F00D);
    set_master(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);

    // Reset pulse while s0 is in RD_D, then a fresh tie.
    set_master(1'b0, 1'b0, 32'h0000_0060, 32'h0, 1'b1);
    waited = 0;
    @(negedge clk);
    while (m_arvalid !== 1'b1 && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    m_arready = 1'b1;
    @(posedge clk);
    #1;
    m_arready = 1'b0;
    #2;
    m_rvalid = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rstmid_quiet", {17'h0, hs_all}, 32'h0);
    check("rstmid_busy", {31'h0, busy}, 32'd0);
    m_rvalid = 1'b0;
    rst_n = 1'b1;
    set_master(1'b1, 1'b0, 32'h0000_0070, 32'h0, 1'b1);
    slave_read(1'b0, 32'h0000_0060, 32'h6666_6666);
    set_master(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    slave_read(1'b1, 32'h0000_0070, 32'h7777_7777);
    set_master(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
